pool_relu_quant_1st: RTL and testbench

//  Post-processing stage directly downstream of the first-layer conv systolic array.

---
 rtl/pool_relu_quant_1st_if.sv | 25 ++
 rtl/pool_relu_quant_1st.sv | 120 ++++++++++++
 tb/tb_pool_relu_quant_1st.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pool_relu_quant_1st_if.sv
// Row handshake bundle for pool_relu_quant_1st: conv rows in, pooled rows out.
interface pool_relu_quant_1st_if #(
  parameter int unsigned NUM_IN = 20,
  parameter int unsigned IN_W   = 32,
  parameter int unsigned OUT_W  = 8
) ();
  logic                         conv_valid_i;
  logic                         conv_ready_o;
  logic [NUM_IN*IN_W-1:0]       conv_i;
  logic [IN_W-1:0]              bias_i;
  logic                         pool_valid_o;
  logic                         pool_ready_i;
  logic [NUM_IN/2*OUT_W-1:0]    pool_o;
  logic [15:0]                  pool_cnt_o;

  modport slave (
    input  conv_valid_i, conv_i, bias_i, pool_ready_i,
    output conv_ready_o, pool_valid_o, pool_o, pool_cnt_o
  );

  modport master (
    output conv_valid_i, conv_i, bias_i, pool_ready_i,
    input  conv_ready_o, pool_valid_o, pool_o, pool_cnt_o
  );
endinterface

// File: rtl/pool_relu_quant_1st.sv
// Bias + ReLU + 7-bit requantize + 2x2 max-pool for first-layer conv rows.
// Even rows are parked in a buffer; odd rows merge with it into one pooled output row.
module pool_relu_quant_1st #(
  parameter int unsigned NUM_IN = 20,
  parameter int unsigned IN_W   = 32,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned SHIFT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pool_relu_quant_1st_if.slave bus
);
  localparam int unsigned NUM_OUT = NUM_IN / 2;
  localparam logic signed [IN_W:0] QMAX = 127;

  typedef enum logic [0:0] {StEven, StOdd} state_e;

  state_e                          state_q, state_d;
  logic [NUM_OUT-1:0][OUT_W-1:0]   buf_q, buf_d;
  logic [NUM_OUT-1:0][OUT_W-1:0]   pool_q, pool_d;
  logic [NUM_OUT-1:0][OUT_W-1:0]   h;
  logic [NUM_IN-1:0][OUT_W-1:0]    q;
  logic                            valid_q, valid_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic                            ready;
  logic                            accept;

  // Sum is one bit wider than the operands, so bias never wraps the conv sum.
  function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] c,
                                             input logic [IN_W-1:0] b);
    logic signed [IN_W:0] s;
    logic signed [IN_W:0] r;
    logic [OUT_W-1:0]     res;
    s   = $signed({c[IN_W-1], c}) + $signed({b[IN_W-1], b});
    r   = s >>> SHIFT;
    res = '0;
    if (s[IN_W]) begin
      res = '0;
    end else if (r > QMAX) begin
      res[6:0] = 7'h7f;
    end else begin
      res[6:0] = r[6:0];
    end
    return res;
  endfunction

  function automatic logic [OUT_W-1:0] max2(input logic [OUT_W-1:0] a,
                                            input logic [OUT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      q[k] = quant(bus.conv_i[k*IN_W +: IN_W], bus.bias_i);
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      h[j] = max2(q[2*j], q[2*j+1]);
    end
  end

  // Even rows never touch the output register, so they are accepted even under stall.
  assign ready  = ~flush & ((state_q == StEven) | ~valid_q | bus.pool_ready_i);
  assign accept = bus.conv_valid_i & ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pool_d  = pool_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = StEven;
      buf_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (valid_q && bus.pool_ready_i) begin
        cnt_d   = cnt_q + 16'd1;
        valid_d = 1'b0;
      end
      if (accept) begin
        unique case (state_q)
          StEven: begin
            buf_d   = h;
            state_d = StOdd;
          end
          StOdd: begin
            for (int j = 0; j < NUM_OUT; j++) begin
              pool_d[j] = max2(buf_q[j], h[j]);
            end
            valid_d = 1'b1;
            state_d = StEven;
          end
          default: state_d = StEven;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEven;
      buf_q   <= '0;
      pool_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pool_q  <= pool_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.conv_ready_o = ready;
  assign bus.pool_valid_o = valid_q;
  assign bus.pool_o       = pool_q;
  assign bus.pool_cnt_o   = cnt_q;
endmodule

// File: tb/tb_pool_relu_quant_1st.sv
// Directed bench for pool_relu_quant_1st: vector table plus stall/flush/reset sequences.
module tb_pool_relu_quant_1st;
  localparam int unsigned NUM_IN = 20;
  localparam int unsigned IN_W   = 32;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned RW     = NUM_IN * IN_W;
  localparam int unsigned PW     = NUM_IN / 2 * OUT_W;

  typedef struct {
    logic [RW-1:0]   conv;
    logic [IN_W-1:0] bias;
    logic [PW-1:0]   pool;
    logic            valid;
    logic [15:0]     cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[10];

  pool_relu_quant_1st_if #(.NUM_IN(NUM_IN), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  pool_relu_quant_1st #(
    .NUM_IN(NUM_IN), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] row_fill(input logic [IN_W-1:0] v);
    logic [RW-1:0] r;
    for (int k = 0; k < NUM_IN; k++) r[k*IN_W +: IN_W] = v;
    return r;
  endfunction

  // Row whose every element quantizes to qv at SHIFT=8 with zero bias.
  function automatic logic [RW-1:0] row_q(input int qv);
    return row_fill(IN_W'(qv * 256));
  endfunction

  function automatic logic [PW-1:0] pool_fill(input logic [7:0] p);
    logic [PW-1:0] r;
    for (int j = 0; j < NUM_IN / 2; j++) r[j*8 +: 8] = p;
    return r;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [PW-1:0] p,
                           input logic [15:0] c);
    check({tag, " valid"}, PW'(bus.pool_valid_o), PW'(v));
    check({tag, " pool"}, bus.pool_o, p);
    check({tag, " cnt"}, PW'(bus.pool_cnt_o), PW'(c));
  endtask

  initial begin
    logic [RW-1:0] r;

    // Test 1: 2560>>8 = 10; 2815 also truncates to 10.
    tbl[0] = '{row_fill(32'd2560), 32'd0, '0, 1'b0, 16'd0};
    tbl[1] = '{row_fill(32'd2815), 32'd0, pool_fill(8'h0a), 1'b1, 16'd0};
    // Test 2: row A q=[1,9,2,8,0...], row B q=[5,3,7,0,0...]; negatives -> 0.
    r = row_fill(32'hffff_ec78);
    r[0*32 +: 32] = 32'd256;  r[1*32 +: 32] = 32'd2304;
    r[2*32 +: 32] = 32'd512;  r[3*32 +: 32] = 32'd2048;
    tbl[2] = '{r, 32'd0, pool_fill(8'h0a), 1'b0, 16'd1};
    r = row_fill(32'hffff_ffff);
    r[0*32 +: 32] = 32'd1280; r[1*32 +: 32] = 32'd768;
    r[2*32 +: 32] = 32'd1792; r[3*32 +: 32] = 32'd0;
    tbl[3] = '{r, 32'd0, {64'd0, 16'h0809}, 1'b1, 16'd1};
    // Test 3: max+max saturates to 127; -100+356 = 256 -> 1.
    tbl[4] = '{row_fill(32'h7fff_ffff), 32'h7fff_ffff, {64'd0, 16'h0809}, 1'b0, 16'd2};
    tbl[5] = '{row_fill(32'hffff_ff9c), 32'd356, pool_fill(8'h7f), 1'b1, 16'd2};
    // min + (-1) must stay negative (a 32-bit wrap would give 127).
    tbl[6] = '{row_fill(32'h8000_0000), 32'hffff_ffff, pool_fill(8'h7f), 1'b0, 16'd3};
    tbl[7] = '{row_fill(32'hffff_ff9c), 32'd356, pool_fill(8'h01), 1'b1, 16'd3};
    // 32767 -> 127 exact, 0x00FFFFFF -> saturate, 25600 -> 100.
    r = '0;
    r[0*32 +: 32] = 32'd32767;      r[1*32 +: 32] = 32'hffff_ffff;
    r[2*32 +: 32] = 32'hffff_8000;  r[4*32 +: 32] = 32'h00ff_ffff;
    tbl[8] = '{r, 32'd0, pool_fill(8'h01), 1'b0, 16'd4};
    r = '0;
    r[2*32 +: 32] = 32'd25600;
    tbl[9] = '{r, 32'd0, {56'd0, 24'h7f647f}, 1'b1, 16'd4};

    rst = 1'b1;
    flush = 1'b0;
    bus.conv_valid_i = 1'b0;
    bus.conv_i = '0;
    bus.bias_i = '0;
    bus.pool_ready_i = 1'b1;
    tick();
    tick();
    check_out("reset", 1'b0, '0, 16'd0);
    check("reset ready", PW'(bus.conv_ready_o), PW'(1'b1));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      bus.conv_valid_i = 1'b1;
      bus.conv_i = tbl[i].conv;
      bus.bias_i = tbl[i].bias;
      #1;
      check($sformatf("v%0d ready", i), PW'(bus.conv_ready_o), PW'(1'b1));
      tick();
      check_out($sformatf("v%0d", i), tbl[i].valid, tbl[i].pool, tbl[i].cnt);
    end

    // Drain, then stall output while rows keep coming.
    bus.conv_valid_i = 1'b0;
    bus.bias_i = '0;
    tick();
    check_out("drain", 1'b0, {56'd0, 24'h7f647f}, 16'd5);
    bus.pool_ready_i = 1'b0;
    bus.conv_valid_i = 1'b1;
    bus.conv_i = row_q(11);
    tick();
    bus.conv_i = row_q(12);
    tick();
    check_out("stall r2", 1'b1, pool_fill(8'h0c), 16'd5);
    bus.conv_i = row_q(13);
    #1;
    check("stall r3 ready", PW'(bus.conv_ready_o), PW'(1'b1));
    tick();
    check_out("stall r3", 1'b1, pool_fill(8'h0c), 16'd5);
    bus.conv_i = row_q(14);
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("stall r4 ready%0d", i), PW'(bus.conv_ready_o), PW'(1'b0));
      tick();
      check_out($sformatf("stall hold%0d", i), 1'b1, pool_fill(8'h0c), 16'd5);
    end
    bus.pool_ready_i = 1'b1;
    #1;
    check("release ready", PW'(bus.conv_ready_o), PW'(1'b1));
    tick();
    check_out("b2b", 1'b1, pool_fill(8'h0e), 16'd6);
    bus.conv_valid_i = 1'b0;
    tick();
    check_out("b2b drain", 1'b0, pool_fill(8'h0e), 16'd7);

    // Flush after an even row: only the following pair may produce output.
    bus.conv_valid_i = 1'b1;
    bus.conv_i = row_q(20);
    tick();
    flush = 1'b1;
    bus.conv_i = row_q(30);
    #1;
    check("flush ready", PW'(bus.conv_ready_o), PW'(1'b0));
    tick();
    flush = 1'b0;
    bus.conv_i = row_q(3);
    tick();
    check("flush even valid", PW'(bus.pool_valid_o), PW'(1'b0));
    bus.conv_i = row_q(4);
    tick();
    check_out("flush pair", 1'b1, pool_fill(8'h04), 16'd7);
    bus.conv_valid_i = 1'b0;
    flush = 1'b1;
    tick();
    check_out("flush drop", 1'b0, pool_fill(8'h04), 16'd7);
    flush = 1'b0;

    // Reset with a stalled output and a half-received pair.
    bus.pool_ready_i = 1'b0;
    bus.conv_valid_i = 1'b1;
    bus.conv_i = row_q(5);
    tick();
    bus.conv_i = row_q(6);
    tick();
    check_out("pre-rst", 1'b1, pool_fill(8'h06), 16'd7);
    bus.conv_i = row_q(7);
    tick();
    rst = 1'b1;
    bus.conv_valid_i = 1'b0;
    tick();
    check_out("mid rst", 1'b0, '0, 16'd0);
    rst = 1'b0;
    bus.pool_ready_i = 1'b1;
    bus.conv_valid_i = 1'b1;
    bus.conv_i = row_q(2);
    tick();
    check("post-rst even valid", PW'(bus.pool_valid_o), PW'(1'b0));
    bus.conv_i = row_q(1);
    tick();
    check_out("post-rst pair", 1'b1, pool_fill(8'h02), 16'd0);
    bus.conv_valid_i = 1'b0;
    tick();
    check_out("post-rst take", 1'b0, pool_fill(8'h02), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end, want end of test");
    $fatal(1);
  end
endmodule
